bastim_ch4: RTL and testbench

//  4-channel basic timer, APB slave in the APB1 domain (0x40001000-0x40001FFF), driven by
//  APB1 slave-mux port 0. Each channel: prescaler + up-counter + auto-reload; on reload it

---
 rtl/bastim_ch4.sv | 129 ++++++++++++
 tb/tb_bastim_ch4.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bastim_ch4.sv
// bastim_ch4: 4-channel prescaled auto-reload timer on a zero-wait APB slave (pready tied 1, no backpressure).
// Reads are combinational; writes, counting and flag updates take effect at the clock edge. BASTIM_DIR_EN adds per-channel down-count.
module bastim_ch4 #(
  parameter int CNT_W = 16,
  parameter int PSC_W = 16
) (
  input  logic        module_clk,
  input  logic        module_rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic [3:0]  bastim_int_line
);
  localparam int NCH = 4;

  logic [3:0]       ctrl_en, ctrl_os, inten, flag, down;
  logic [PSC_W-1:0] psc     [NCH];
  logic [PSC_W-1:0] psc_cnt [NCH];
  logic [CNT_W-1:0] arr     [NCH];
  logic [CNT_W-1:0] cnt     [NCH];

  logic [9:0]     word;
  logic           wr, mapped, sel_ctrl, sel_inten, sel_sts;
  logic [NCH-1:0] sel_psc, sel_arr, sel_cnt, tick, wrap, hit;
  logic [31:0]    rd_dat;
  logic           unused_bits;

`ifdef BASTIM_DIR_EN
  logic [3:0] ctrl_dir;
  assign down = ctrl_dir;
`else
  assign down = 4'd0;
`endif

  assign word        = paddr[11:2];
  assign wr          = psel & penable & pwrite;
  assign unused_bits = ^{paddr[1:0], pwdata};

  always_comb begin
    sel_ctrl  = (word == 10'd0);
    sel_inten = (word == 10'd1);
    sel_sts   = (word == 10'd2);
    for (int n = 0; n < NCH; n++) begin
      sel_psc[n] = (word == 10'(4 + 4 * n));
      sel_arr[n] = (word == 10'(5 + 4 * n));
      sel_cnt[n] = (word == 10'(6 + 4 * n));
    end
    mapped = sel_ctrl | sel_inten | sel_sts | (|sel_psc) | (|sel_arr) | (|sel_cnt);
  end

  always_comb begin
    rd_dat = '0;
    if (sel_ctrl)  rd_dat = {20'd0, down, ctrl_os, ctrl_en};
    if (sel_inten) rd_dat = {28'd0, inten};
    if (sel_sts)   rd_dat = {28'd0, flag};
    for (int n = 0; n < NCH; n++) begin
      if (sel_psc[n]) rd_dat = 32'(psc[n]);
      if (sel_arr[n]) rd_dat = 32'(arr[n]);
      if (sel_cnt[n]) rd_dat = 32'(cnt[n]);
    end
  end

  assign prdata          = (psel & ~pwrite) ? rd_dat : 32'd0;
  assign pready          = 1'b1;
  assign pslverr         = psel & penable & ~mapped;
  assign bastim_int_line = flag & inten;

  // Terminal test uses >= so lowering ARR below CNT reloads on the next tick instead of wrapping.
  // A CNT write in the same cycle suppresses the reload and its flag.
  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      tick[n] = ctrl_en[n] & (psc_cnt[n] == psc[n]);
      wrap[n] = down[n] ? (cnt[n] == '0) : (cnt[n] >= arr[n]);
      hit[n]  = tick[n] & wrap[n] & ~(wr & sel_cnt[n]);
    end
  end

  always_ff @(posedge module_clk) begin
    if (module_rst) begin
      ctrl_en <= '0;
      ctrl_os <= '0;
      inten   <= '0;
      flag    <= '0;
`ifdef BASTIM_DIR_EN
      ctrl_dir <= '0;
`endif
      for (int n = 0; n < NCH; n++) begin
        psc[n]     <= '0;
        psc_cnt[n] <= '0;
        arr[n]     <= '0;
        cnt[n]     <= '0;
      end
    end else begin
      if (wr & sel_ctrl) begin
        ctrl_en <= pwdata[3:0];
        ctrl_os <= pwdata[7:4];
`ifdef BASTIM_DIR_EN
        ctrl_dir <= pwdata[11:8];
`endif
      end else begin
        ctrl_en <= ctrl_en & ~(hit & ctrl_os);
      end
      if (wr & sel_inten) inten <= pwdata[3:0];
      // Set has priority over a same-cycle W1C.
      flag <= (flag & ~({4{wr & sel_sts}} & pwdata[3:0])) | hit;
      for (int n = 0; n < NCH; n++) begin
        if (wr & sel_psc[n]) psc[n] <= pwdata[PSC_W-1:0];
        if (wr & sel_arr[n]) arr[n] <= pwdata[CNT_W-1:0];
        if (wr & sel_cnt[n]) begin
          cnt[n]     <= '0;
          psc_cnt[n] <= '0;
        end else if (ctrl_en[n]) begin
          if (tick[n]) begin
            psc_cnt[n] <= '0;
            if (wrap[n]) cnt[n] <= down[n] ? arr[n] : '0;
            else         cnt[n] <= down[n] ? cnt[n] - CNT_W'(1) : cnt[n] + CNT_W'(1);
          end else begin
            psc_cnt[n] <= psc_cnt[n] + PSC_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_bastim_ch4.sv
// Bench for bastim_ch4: cycle model of the timer rules checked every negedge, plus directed
// register/timing scenarios with hand-computed values (default widths, CNT_W=PSC_W=16).
`timescale 1ns/1ps
module tb_bastim_ch4;
  logic        clk, rst, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [3:0]  int_line;

  int checks, failures;
  int cyc = 0;

  logic [3:0]  m_en, m_os, m_dir, m_inten, m_flag;
  int unsigned m_psc [4];
  int unsigned m_arr [4];
  int unsigned m_cnt [4];
  int unsigned m_ph  [4];

  bastim_ch4 dut (
    .module_clk(clk), .module_rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .bastim_int_line(int_line)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: phase counts clocks inside a prescaler period; count advances per period.
  always @(posedge clk) begin : model
    logic [3:0] hit;
    logic       wr;
    int         off;
    wr  = psel && penable && pwrite;
    off = int'(paddr[11:2]) * 4;
    if (rst) begin
      m_en = 0; m_os = 0; m_dir = 0; m_inten = 0; m_flag = 0;
      for (int c = 0; c < 4; c++) begin
        m_psc[c] = 0; m_arr[c] = 0; m_cnt[c] = 0; m_ph[c] = 0;
      end
    end else begin
      hit = 4'd0;
      for (int c = 0; c < 4; c++) begin
        if (wr && off == 16 + 16 * c + 8) begin
          m_cnt[c] = 0; m_ph[c] = 0;
        end else if (m_en[c]) begin
          if (m_ph[c] != m_psc[c]) m_ph[c] = m_ph[c] + 1;
          else begin
            m_ph[c] = 0;
            if (m_dir[c]) begin
              if (m_cnt[c] == 0) begin m_cnt[c] = m_arr[c]; hit[c] = 1'b1; end
              else m_cnt[c] = m_cnt[c] - 1;
            end else if (m_cnt[c] >= m_arr[c]) begin
              m_cnt[c] = 0; hit[c] = 1'b1;
            end else m_cnt[c] = (m_cnt[c] + 1) & 32'hFFFF;
          end
        end
      end
      if (wr && off == 8) m_flag = m_flag & ~pwdata[3:0];
      m_flag = m_flag | hit;
      if (wr && off == 0) begin
        m_en = pwdata[3:0]; m_os = pwdata[7:4];
`ifdef BASTIM_DIR_EN
        m_dir = pwdata[11:8];
`endif
      end else m_en = m_en & ~(hit & m_os);
      if (wr && off == 4) m_inten = pwdata[3:0];
      for (int c = 0; c < 4; c++) begin
        if (wr && off == 16 + 16 * c) m_psc[c] = pwdata & 32'hFFFF;
        if (wr && off == 16 + 16 * c + 4) m_arr[c] = pwdata & 32'hFFFF;
      end
    end
  end

  function automatic bit model_mapped(input logic [11:0] a);
    int off;
    off = int'(a[11:2]) * 4;
    if (off <= 8) return 1'b1;
    if (off >= 16 && off < 80 && (off % 16) != 12) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    int off, c;
    off = int'(a[11:2]) * 4;
    if (!model_mapped(a)) return 32'd0;
    if (off == 0) return {20'd0, m_dir, m_os, m_en};
    if (off == 4) return {28'd0, m_inten};
    if (off == 8) return {28'd0, m_flag};
    c = (off - 16) / 16;
    case (off % 16)
      0:       return m_psc[c];
      4:       return m_arr[c];
      default: return m_cnt[c];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      chk("int_line", {28'd0, int_line}, {28'd0, m_flag & m_inten});
      chk("pready", {31'd0, pready}, 32'd1);
      chk("prdata", prdata, (psel && !pwrite) ? model_rd(paddr) : 32'd0);
      chk("pslverr", {31'd0, pslverr}, {31'd0, psel && penable && !model_mapped(paddr)});
    end
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    d = prdata; e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_int(input int ch, input int limit, output int dt);
    int start;
    start = cyc; dt = -1;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (int_line[ch]) begin dt = cyc - start; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [11:0] off;
    int          dt, t0;
    clk = 0; rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    checks = 0; failures = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    fork compare_loop(); join_none

    // Reset state of all mapped registers, then an unmapped offset.
    chk("rst_int", {28'd0, int_line}, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      off = (i < 3) ? 12'(4 * i) : 12'(16 + 16 * ((i - 3) / 3) + 4 * ((i - 3) % 3));
      apb_read(off, d, e);
      chk("t1_reg_zero", d, 32'd0);
      chk("t1_no_err", {31'd0, e}, 32'd0);
    end
    apb_read(12'h0FC, d, e);
    chk("t1_unmapped_err", {31'd0, e}, 32'd1);
    chk("t1_unmapped_dat", d, 32'd0);

    // Ch0 PSC=3 ARR=4: first flag 20 clk after enable; W1C landing on the set edge loses.
    apb_write(12'h010, 32'd3); apb_write(12'h014, 32'd4); apb_write(12'h004, 32'd1);
    apb_write(12'h000, 32'd1); t0 = cyc;
    wait_int(0, 100, dt);
    chk("t2_first_flag_clks", dt, 32'd20);
    apb_write(12'h008, 32'd1);
    chk("t4_w1c_clears", {31'd0, int_line[0]}, 32'd0);
    while (cyc < t0 + 37) begin @(posedge clk); #1; end
    apb_write(12'h008, 32'd1);
    chk("t2_period_flag", {31'd0, int_line[0]}, 32'd1);
    apb_read(12'h008, d, e);
    chk("t4_set_wins", d & 32'd1, 32'd1);
    apb_write(12'h008, 32'd1);
    apb_read(12'h008, d, e);
    chk("t4_w1c_alone", d & 32'd1, 32'd0);
    apb_write(12'h000, 32'd0);

    // One-shot ch1: single flag at 10 clk, EN self-clears, CNT parks at 0.
    apb_write(12'h004, 32'hF);
    apb_write(12'h020, 32'd0); apb_write(12'h024, 32'd9); apb_write(12'h000, 32'h22);
    wait_int(1, 100, dt);
    chk("t3_oneshot_clks", dt, 32'd10);
    apb_read(12'h000, d, e);
    chk("t3_ctrl_after", d, 32'h20);
    apb_read(12'h028, d, e);
    chk("t3_cnt1_zero", d, 32'd0);
    apb_read(12'h008, d, e);
    chk("t3_sts_only_ch1", d, 32'h2);
    apb_write(12'h008, 32'h2);
    repeat (20) @(posedge clk);
    #1;
    apb_read(12'h028, d, e);
    chk("t3_cnt1_held", d, 32'd0);
    apb_read(12'h008, d, e);
    chk("t3_no_second_flag", d, 32'd0);

    // Ch2 run to 50, lower ARR to 10: next tick reloads to 0 with a flag.
    apb_write(12'h030, 32'd0); apb_write(12'h034, 32'd100); apb_write(12'h000, 32'd4); t0 = cyc;
    while (cyc < t0 + 47) begin @(posedge clk); #1; end
    apb_write(12'h000, 32'd0);
    apb_read(12'h038, d, e);
    chk("t5_cnt_held", d, 32'd50);
    apb_write(12'h034, 32'd10);
    apb_read(12'h038, d, e);
    chk("t5_cnt_still_50", d, 32'd50);
    apb_write(12'h000, 32'd4);
    wait_int(2, 50, dt);
    chk("t5_reload_next_tick", dt, 32'd1);
    apb_read(12'h038, d, e);
    chk("t5_count_from_zero", d, 32'd2);
    apb_write(12'h000, 32'd0);
    apb_write(12'h038, 32'hABCD);
    apb_read(12'h038, d, e);
    chk("t5_cnt_write_clears", d, 32'd0);
    apb_write(12'h008, 32'h4);

`ifdef BASTIM_DIR_EN
    // Ch3 down-count ARR=5: reload to 5 on the first tick, then flag every 6 clk.
    apb_write(12'h040, 32'd0); apb_write(12'h044, 32'd5); apb_write(12'h000, 32'h808); t0 = cyc;
    apb_read(12'h048, d, e);
    chk("t6_down_cnt", d, 32'd4);
    apb_write(12'h008, 32'h8);
    wait_int(3, 50, dt);
    chk("t6_flag_period", cyc - t0, 32'd7);
    apb_read(12'h000, d, e);
    chk("t6_dir_readback", d, 32'h808);
    apb_write(12'h000, 32'd0);
`else
    apb_write(12'h000, 32'hF00);
    apb_read(12'h000, d, e);
    chk("t6_dir_ignored", d, 32'd0);
`endif

    // Reset while ch0 is counting with a pending flag.
    apb_write(12'h010, 32'd0); apb_write(12'h014, 32'd3); apb_write(12'h000, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_pre_flag", {31'd0, int_line[0]}, 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_mid_int", {28'd0, int_line}, 32'd0);
    apb_read(12'h000, d, e); chk("rst_mid_ctrl", d, 32'd0);
    apb_read(12'h008, d, e); chk("rst_mid_sts", d, 32'd0);
    apb_read(12'h014, d, e); chk("rst_mid_arr0", d, 32'd0);
    apb_read(12'h018, d, e); chk("rst_mid_cnt0", d, 32'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
